// File: rtl/wb_regfile.sv
// Integer register file with write-back bypass, per-register pending-write
// scoreboard for issue hazard detection, and a retired-instruction counter.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_rd_ena,
  input  logic [4:0]  wb_rd_addr,
  input  logic [63:0] wb_rd_data,
  input  logic [63:0] wb_pc,
  input  logic        rs1_ena,
  input  logic [4:0]  rs1_addr,
  input  logic        rs2_ena,
  input  logic [4:0]  rs2_addr,
  output logic [63:0] rs1_data,
  output logic [63:0] rs2_data,
  input  logic        issue_valid,
  input  logic        issue_rd_ena,
  input  logic [4:0]  issue_rd_addr,
  input  logic        flush,
  output logic        hazard_stall,
  output logic [63:0] retire_cnt
);

  logic [63:0] regs [32];
  logic [1:0]  pend [32];

  logic        wb_wr;
  logic        issue_acc;
  logic [31:0] iss_hit;
  logic [31:0] wb_hit;
  logic        rs1_pend;
  logic        rs2_pend;

  assign wb_wr     = wb_rd_ena && (wb_rd_addr != 5'd0);
  assign issue_acc = issue_valid && issue_rd_ena && (issue_rd_addr != 5'd0)
                     && !hazard_stall && !flush;

  always_comb begin
    iss_hit = '0;
    wb_hit  = '0;
    for (int i = 1; i < 32; i++) begin
      iss_hit[i] = issue_acc && (issue_rd_addr == 5'(i));
      wb_hit[i]  = wb_wr && (wb_rd_addr == 5'(i));
    end
  end

  always_comb begin
    rs1_data = 64'h0;
    rs2_data = 64'h0;
    if (rs1_ena && rs1_addr != 5'd0) begin
      if (wb_rd_ena && wb_rd_addr == rs1_addr) rs1_data = wb_rd_data;
      else                                     rs1_data = regs[rs1_addr];
    end
    if (rs2_ena && rs2_addr != 5'd0) begin
      if (wb_rd_ena && wb_rd_addr == rs2_addr) rs2_data = wb_rd_data;
      else                                     rs2_data = regs[rs2_addr];
    end
  end

  // A write-back landing this cycle retires one pending write to that register,
  // so a count of 1 with a matching write-back is no longer a hazard.
  always_comb begin
    rs1_pend = (pend[rs1_addr] != 2'd0) &&
               !(wb_wr && wb_rd_addr == rs1_addr && pend[rs1_addr] == 2'd1);
    rs2_pend = (pend[rs2_addr] != 2'd0) &&
               !(wb_wr && wb_rd_addr == rs2_addr && pend[rs2_addr] == 2'd1);
  end

  always_comb begin
    hazard_stall = 1'b0;
    if (issue_valid && !flush) begin
      if (rs1_ena && rs1_addr != 5'd0 && rs1_pend) hazard_stall = 1'b1;
      if (rs2_ena && rs2_addr != 5'd0 && rs2_pend) hazard_stall = 1'b1;
      if (issue_rd_ena && issue_rd_addr != 5'd0 && pend[issue_rd_addr] == 2'd3)
        hazard_stall = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 64'h0;
        pend[i] <= 2'd0;
      end
      retire_cnt <= 64'h0;
    end else begin
      if (wb_pc != 64'h0) retire_cnt <= retire_cnt + 64'd1;
      if (wb_wr) regs[wb_rd_addr] <= wb_rd_data;
      // Flush wins over any same-cycle issue/write-back count change.
      for (int i = 1; i < 32; i++) begin
        if (flush)
          pend[i] <= 2'd0;
        else if (iss_hit[i] && !wb_hit[i])
          pend[i] <= pend[i] + 2'd1;
        else if (wb_hit[i] && !iss_hit[i] && pend[i] != 2'd0)
          pend[i] <= pend[i] - 2'd1;
      end
    end
  end

endmodule
